// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared commit-stage types and op classification helpers
package ariane_pkg;

  typedef enum logic [2:0] {
    FU_NONE, FU_ALU, FU_LOAD, FU_STORE, FU_CSR, FU_FPU
  } fu_e;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_LD, OP_SD, OP_CSRRW, OP_CSRRS, OP_FENCE, OP_FENCE_I,
    OP_SFENCE_VMA, OP_AMO_ADD, OP_AMO_SWAP, OP_FADD
  } fu_op_e;

  typedef enum logic [1:0] {
    IDLE, DRAIN, AMO_WAIT, FLUSH
  } commit_fsm_e;

  typedef struct packed {
    logic        valid;
    logic [63:0] cause;
    logic [63:0] tval;
  } exception_t;

  typedef struct packed {
    logic        ack;
    logic [63:0] result;
  } amo_resp_t;

  // FP entries carry their accrued fflags in ex.cause[4:0] with ex.valid = 0
  typedef struct packed {
    logic       valid;
    fu_e        fu;
    fu_op_e     op;
    logic [4:0] rd;
    logic [63:0] result;
    exception_t ex;
  } scoreboard_entry_t;

  function automatic logic is_fence(fu_op_e op);
    return op inside {OP_FENCE, OP_FENCE_I, OP_SFENCE_VMA};
  endfunction

  function automatic logic is_amo(fu_op_e op);
    return op inside {OP_AMO_ADD, OP_AMO_SWAP};
  endfunction

  function automatic logic is_serialising(fu_op_e op);
    return is_fence(op) || is_amo(op);
  endfunction

  function automatic logic writes_gpr(scoreboard_entry_t e);
    return (e.fu inside {FU_ALU, FU_LOAD, FU_CSR}) && !is_serialising(e.op);
  endfunction

endpackage

// File: rtl/commit_prefix_sel.sv
// rtl/commit_prefix_sel.sv - per-port retire eligibility folded into a contiguous prefix
module commit_prefix_sel
  import ariane_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS      = 4,
  parameter int unsigned MAX_STORES_PER_CYCLE = 1
) (
  input  logic [NR_COMMIT_PORTS-1:0]      valid_i,
  input  logic [NR_COMMIT_PORTS-1:0]      ex_i,
  input  logic [NR_COMMIT_PORTS-1:0]      store_i,
  input  logic [NR_COMMIT_PORTS-1:0]      port0_only_i,
  input  logic                            halt_i,
  input  logic                            single_step_i,
  input  logic                            fsm_idle_i,
  input  logic                            release0_i,
  input  logic                            head_blocked_i,
  input  logic [MAX_STORES_PER_CYCLE-1:0] lsu_ready_i,
  output logic [NR_COMMIT_PORTS-1:0]      ack_o,
  output logic [MAX_STORES_PER_CYCLE-1:0] lsu_o
);

  always_comb begin
    logic go;
    logic elig;
    logic slot_ok;
    int   n_st;
    ack_o   = '0;
    lsu_o   = '0;
    go      = !halt_i;
    n_st    = 0;
    elig    = 1'b0;
    slot_ok = 1'b0;
    for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
      elig = go && valid_i[k] && !ex_i[k];
      // port 0 is either a plain retire (IDLE) or handed over by the sequencer
      if (k == 0) elig = elig && (fsm_idle_i ? !head_blocked_i : release0_i);
      else        elig = elig && fsm_idle_i && !port0_only_i[k] && !single_step_i;
      if (store_i[k]) begin
        slot_ok = 1'b0;
        for (int j = 0; j < int'(MAX_STORES_PER_CYCLE); j++)
          if (n_st == j) slot_ok = lsu_ready_i[j];
        elig = elig && slot_ok;
        if (elig) begin
          for (int j = 0; j < int'(MAX_STORES_PER_CYCLE); j++)
            if (n_st == j) lsu_o[j] = 1'b1;
          n_st = n_st + 1;
        end
      end
      ack_o[k] = elig;
      go = elig && !port0_only_i[k];
    end
  end

endmodule

// File: rtl/commit_stage_mp.sv
// rtl/commit_stage_mp.sv - multi-port in-order commit with serialising sequencer
module commit_stage_mp
  import ariane_pkg::*;
#(
  parameter int unsigned NR_COMMIT_PORTS      = 4,
  parameter int unsigned MAX_STORES_PER_CYCLE = 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   halt_i,
  input  logic                                   single_step_i,
  input  scoreboard_entry_t [NR_COMMIT_PORTS-1:0] commit_instr_i,
  output logic [NR_COMMIT_PORTS-1:0]             commit_ack_o,
  output logic [NR_COMMIT_PORTS-1:0][4:0]        waddr_o,
  output logic [NR_COMMIT_PORTS-1:0][63:0]       wdata_o,
  output logic [NR_COMMIT_PORTS-1:0]             we_gpr_o,
  output logic [NR_COMMIT_PORTS-1:0]             we_fpr_o,
  output logic [$clog2(NR_COMMIT_PORTS+1)-1:0]   n_retired_o,
  output logic [MAX_STORES_PER_CYCLE-1:0]        commit_lsu_o,
  input  logic [MAX_STORES_PER_CYCLE-1:0]        commit_lsu_ready_i,
  input  logic                                   no_st_pending_i,
  input  amo_resp_t                              amo_resp_i,
  output logic                                   amo_valid_commit_o,
  output fu_op_e                                 csr_op_o,
  output logic [63:0]                            csr_wdata_o,
  input  logic [63:0]                            csr_rdata_i,
  input  exception_t                             csr_exception_i,
  output logic                                   csr_write_fflags_o,
  output logic                                   fence_o,
  output logic                                   fence_i_o,
  output logic                                   sfence_vma_o,
  output logic                                   flush_commit_o,
  output logic                                   dirty_fp_state_o,
  output exception_t                             exception_o
);

  localparam int unsigned CW = $clog2(NR_COMMIT_PORTS + 1);

  commit_fsm_e state_q, state_d;
  logic        halt_eff, head_ok, csr_at_head, head_blocked;
  logic        release0, amo_wb;
  fu_op_e      head_op;
  logic [NR_COMMIT_PORTS-1:0] valid_v, ex_v, store_v, port0_only_v;
  logic        unused_bits;

  // a reset cycle behaves like a halt so no combinational retire leaks out
  assign halt_eff    = halt_i || !rst_ni;
  assign head_op     = commit_instr_i[0].op;
  assign head_ok     = commit_instr_i[0].valid && !commit_instr_i[0].ex.valid;
  assign csr_at_head = head_ok && !halt_eff && (state_q == IDLE) &&
                       (commit_instr_i[0].fu == FU_CSR) && !is_serialising(head_op);
  assign head_blocked = is_serialising(head_op) ||
                        ((commit_instr_i[0].fu == FU_CSR) && csr_exception_i.valid);
  assign unused_bits = ^{csr_exception_i.tval, commit_instr_i};

  always_comb begin
    for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
      valid_v[k]      = commit_instr_i[k].valid;
      ex_v[k]         = commit_instr_i[k].ex.valid;
      store_v[k]      = (commit_instr_i[k].fu == FU_STORE) && !is_amo(commit_instr_i[k].op);
      port0_only_v[k] = (commit_instr_i[k].fu == FU_CSR) || is_serialising(commit_instr_i[k].op);
    end
  end

  commit_prefix_sel #(
    .NR_COMMIT_PORTS      (NR_COMMIT_PORTS),
    .MAX_STORES_PER_CYCLE (MAX_STORES_PER_CYCLE)
  ) u_prefix_sel (
    .valid_i        (valid_v),
    .ex_i           (ex_v),
    .store_i        (store_v),
    .port0_only_i   (port0_only_v),
    .halt_i         (halt_eff),
    .single_step_i  (single_step_i),
    .fsm_idle_i     (state_q == IDLE),
    .release0_i     (release0),
    .head_blocked_i (head_blocked),
    .lsu_ready_i    (commit_lsu_ready_i),
    .ack_o          (commit_ack_o),
    .lsu_o          (commit_lsu_o)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d            = state_q;
    release0           = 1'b0;
    amo_wb             = 1'b0;
    fence_o            = 1'b0;
    fence_i_o          = 1'b0;
    sfence_vma_o       = 1'b0;
    flush_commit_o     = 1'b0;
    amo_valid_commit_o = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (head_ok && !halt_eff) begin
          if (is_fence(head_op))    state_d = DRAIN;
          else if (is_amo(head_op)) state_d = AMO_WAIT;
        end
      end
      DRAIN: begin
        if (no_st_pending_i && !halt_eff && head_ok) begin
          release0     = 1'b1;
          fence_o      = (head_op == OP_FENCE);
          fence_i_o    = (head_op == OP_FENCE_I);
          sfence_vma_o = (head_op == OP_SFENCE_VMA);
          state_d      = FLUSH;
        end
      end
      AMO_WAIT: begin
        amo_valid_commit_o = rst_ni;
        if (amo_resp_i.ack && !halt_eff && head_ok) begin
          release0       = 1'b1;
          amo_wb         = 1'b1;
          flush_commit_o = 1'b1;
          state_d        = FLUSH;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // controller flush aborts the sequence silently
    if (flush_i) begin
      state_d        = IDLE;
      release0       = 1'b0;
      amo_wb         = 1'b0;
      fence_o        = 1'b0;
      fence_i_o      = 1'b0;
      sfence_vma_o   = 1'b0;
      flush_commit_o = 1'b0;
    end
  end

  always_comb begin
    csr_op_o           = OP_ADD;
    csr_wdata_o        = '0;
    csr_write_fflags_o = 1'b0;
    for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
      waddr_o[k]  = commit_instr_i[k].rd;
      wdata_o[k]  = commit_instr_i[k].result;
      we_gpr_o[k] = commit_ack_o[k] && writes_gpr(commit_instr_i[k]);
      we_fpr_o[k] = commit_ack_o[k] && (commit_instr_i[k].fu == FU_FPU);
    end
    if (csr_at_head) begin
      csr_op_o    = head_op;
      csr_wdata_o = commit_instr_i[0].result;
      if (!csr_exception_i.valid) wdata_o[0] = csr_rdata_i;
    end else begin
      for (int k = 0; k < int'(NR_COMMIT_PORTS); k++) begin
        if (we_fpr_o[k]) begin
          csr_wdata_o[4:0]   = csr_wdata_o[4:0] | commit_instr_i[k].ex.cause[4:0];
          csr_write_fflags_o = 1'b1;
        end
      end
    end
    if (amo_wb) begin
      wdata_o[0]  = amo_resp_i.result;
      we_gpr_o[0] = 1'b1;
    end
  end

  assign dirty_fp_state_o = |we_fpr_o;

  always_comb begin
    n_retired_o = '0;
    for (int k = 0; k < int'(NR_COMMIT_PORTS); k++)
      n_retired_o = n_retired_o + CW'(commit_ack_o[k]);
  end

  always_comb begin
    exception_o = '0;
    if (!halt_eff && commit_instr_i[0].valid) begin
      if (commit_instr_i[0].ex.valid) begin
        exception_o = commit_instr_i[0].ex;
      end else if (csr_at_head && csr_exception_i.valid) begin
        exception_o      = csr_exception_i;
        exception_o.tval = commit_instr_i[0].ex.tval;
      end
    end
  end

endmodule

// File: tb/tb_commit_stage_mp.sv
// tb/tb_commit_stage_mp.sv - directed self-checking bench for commit_stage_mp
module tb_commit_stage_mp;
  import ariane_pkg::*;

  logic clk = 1'b0;
  logic rst_ni, flush_i, halt_i, single_step_i;
  scoreboard_entry_t [3:0] instr;
  logic [3:0] ack, we_gpr, we_fpr;
  logic [3:0][4:0] waddr;
  logic [3:0][63:0] wdata;
  logic [2:0] n_retired;
  logic [0:0] lsu, lsu_ready;
  logic no_st, amo_valid, fflags, fence, fence_i, sfence, flush_commit, dirty_fp;
  amo_resp_t amo_resp;
  fu_op_e csr_op;
  logic [63:0] csr_wdata, csr_rdata;
  exception_t csr_exc, exc;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  commit_stage_mp #(.NR_COMMIT_PORTS(4), .MAX_STORES_PER_CYCLE(1)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .halt_i(halt_i),
    .single_step_i(single_step_i), .commit_instr_i(instr), .commit_ack_o(ack),
    .waddr_o(waddr), .wdata_o(wdata), .we_gpr_o(we_gpr), .we_fpr_o(we_fpr),
    .n_retired_o(n_retired), .commit_lsu_o(lsu), .commit_lsu_ready_i(lsu_ready),
    .no_st_pending_i(no_st), .amo_resp_i(amo_resp), .amo_valid_commit_o(amo_valid),
    .csr_op_o(csr_op), .csr_wdata_o(csr_wdata), .csr_rdata_i(csr_rdata),
    .csr_exception_i(csr_exc), .csr_write_fflags_o(fflags), .fence_o(fence),
    .fence_i_o(fence_i), .sfence_vma_o(sfence), .flush_commit_o(flush_commit),
    .dirty_fp_state_o(dirty_fp), .exception_o(exc)
  );

  function automatic scoreboard_entry_t mk(fu_e fu, fu_op_e op, logic [4:0] rd, logic [63:0] res);
    scoreboard_entry_t e;
    e = '0; e.valid = 1'b1; e.fu = fu; e.op = op; e.rd = rd; e.result = res;
    return e;
  endfunction

  function automatic scoreboard_entry_t alu(int k);
    return mk(FU_ALU, OP_ADD, 5'(k + 1), 64'h100 + 64'(k));
  endfunction

  task automatic next_cycle; @(posedge clk); #1; endtask

  task automatic clear_inputs;
    instr = '0; flush_i = 0; halt_i = 0; single_step_i = 0; no_st = 1; lsu_ready = 1;
    amo_resp = '0; csr_rdata = '0; csr_exc = '0;
  endtask

  task automatic test_reset;
    clear_inputs(); rst_ni = 0;
    for (int k = 0; k < 4; k++) instr[k] = alu(k);
    next_cycle(); #1;
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got %b exp 0000", ack); end
    n_checks++; if (n_retired !== 3'd0) begin n_fail++; $display("FAIL reset_nret got %0d exp 0", n_retired); end
    n_checks++; if (we_gpr !== 4'b0 || fflags !== 1'b0 || fence !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b/%b/%b exp 0", we_gpr, fflags, fence); end
    n_checks++; if (exc.valid !== 1'b0) begin n_fail++; $display("FAIL reset_exc got %b exp 0", exc.valid); end
    n_checks++; if (csr_op !== OP_ADD) begin n_fail++; $display("FAIL reset_csr_op got %0d exp %0d", csr_op, OP_ADD); end
    rst_ni = 1; next_cycle();
  endtask

  task automatic test_alu_group;
    clear_inputs();
    for (int k = 0; k < 4; k++) instr[k] = alu(k);
    #1;
    n_checks++; if (ack !== 4'b1111) begin n_fail++; $display("FAIL alu_ack got %b exp 1111", ack); end
    n_checks++; if (n_retired !== 3'd4) begin n_fail++; $display("FAIL alu_nret got %0d exp 4", n_retired); end
    n_checks++; if (we_gpr !== 4'b1111) begin n_fail++; $display("FAIL alu_we got %b exp 1111", we_gpr); end
    n_checks++; if (wdata[2] !== 64'h102 || waddr[3] !== 5'd4) begin n_fail++; $display("FAIL alu_wr got %h/%0d exp 102/4", wdata[2], waddr[3]); end
    next_cycle();
  endtask

  task automatic test_stores;
    clear_inputs();
    instr[0] = alu(0); instr[1] = mk(FU_STORE, OP_SD, 0, 0);
    instr[2] = mk(FU_STORE, OP_SD, 0, 0); instr[3] = alu(3);
    #1;
    n_checks++; if (ack !== 4'b0011) begin n_fail++; $display("FAIL st_ack got %b exp 0011", ack); end
    n_checks++; if (lsu !== 1'b1) begin n_fail++; $display("FAIL st_lsu got %b exp 1", lsu); end
    n_checks++; if (we_gpr !== 4'b0001) begin n_fail++; $display("FAIL st_we got %b exp 0001", we_gpr); end
    lsu_ready = 0; #1;
    n_checks++; if (ack !== 4'b0001 || lsu !== 1'b0) begin n_fail++; $display("FAIL st_notready got %b/%b exp 0001/0", ack, lsu); end
    next_cycle();
  endtask

  task automatic test_step_halt;
    clear_inputs();
    for (int k = 0; k < 4; k++) instr[k] = alu(k);
    single_step_i = 1; #1;
    n_checks++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL step_ack got %b exp 0001", ack); end
    single_step_i = 0; halt_i = 1; #1;
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL halt_ack got %b exp 0000", ack); end
    next_cycle();
  endtask

  task automatic test_exception;
    clear_inputs();
    for (int k = 0; k < 4; k++) instr[k] = alu(k);
    instr[2].ex.valid = 1; #1;
    n_checks++; if (ack !== 4'b0011 || exc.valid !== 1'b0) begin n_fail++; $display("FAIL ex2 got %b/%b exp 0011/0", ack, exc.valid); end
    instr[0].ex = '{valid: 1'b1, cause: 64'd2, tval: 64'hBAD}; #1;
    n_checks++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL ex0_ack got %b exp 0000", ack); end
    n_checks++; if (exc.valid !== 1'b1 || exc.cause !== 64'd2 || exc.tval !== 64'hBAD) begin n_fail++; $display("FAIL ex0_exc got %b/%h/%h exp 1/2/bad", exc.valid, exc.cause, exc.tval); end
    instr[0] = '0; #1;
    n_checks++; if (ack !== 4'b0000 || exc.valid !== 1'b0) begin n_fail++; $display("FAIL head_invalid got %b/%b exp 0000/0", ack, exc.valid); end
    next_cycle();
  endtask

  task automatic test_fp;
    clear_inputs();
    instr[0] = mk(FU_FPU, OP_FADD, 1, 0); instr[0].ex.cause = 64'h1;
    instr[1] = mk(FU_FPU, OP_FADD, 2, 0); instr[1].ex.cause = 64'h4;
    instr[2] = alu(2); instr[3] = alu(3); #1;
    n_checks++; if (ack !== 4'b1111) begin n_fail++; $display("FAIL fp_ack got %b exp 1111", ack); end
    n_checks++; if (we_fpr !== 4'b0011 || we_gpr !== 4'b1100) begin n_fail++; $display("FAIL fp_we got %b/%b exp 0011/1100", we_fpr, we_gpr); end
    n_checks++; if (fflags !== 1'b1 || csr_wdata !== 64'h5 || dirty_fp !== 1'b1) begin n_fail++; $display("FAIL fp_flags got %b/%h/%b exp 1/5/1", fflags, csr_wdata, dirty_fp); end
    next_cycle();
  endtask

  task automatic test_csr;
    clear_inputs();
    instr[0] = alu(0); instr[1] = mk(FU_CSR, OP_CSRRW, 7, 64'h55);
    instr[2] = alu(2); instr[3] = alu(3); csr_rdata = 64'h77; #1;
    n_checks++; if (ack !== 4'b0001 || csr_op !== OP_ADD) begin n_fail++; $display("FAIL csr_behind got %b/%0d exp 0001/%0d", ack, csr_op, OP_ADD); end
    next_cycle();
    instr[0] = mk(FU_CSR, OP_CSRRW, 7, 64'h55); instr[0].ex.tval = 64'h1234;
    instr[1] = alu(1); instr[2] = alu(2); instr[3] = alu(3); #1;
    n_checks++; if (ack !== 4'b0001 || we_gpr !== 4'b0001) begin n_fail++; $display("FAIL csr_head got %b/%b exp 0001/0001", ack, we_gpr); end
    n_checks++; if (wdata[0] !== 64'h77 || csr_op !== OP_CSRRW || csr_wdata !== 64'h55) begin n_fail++; $display("FAIL csr_data got %h/%0d/%h exp 77/%0d/55", wdata[0], csr_op, csr_wdata, OP_CSRRW); end
    csr_exc = '{valid: 1'b1, cause: 64'd2, tval: 64'h999}; #1;
    n_checks++; if (ack !== 4'b0000 || we_gpr !== 4'b0000) begin n_fail++; $display("FAIL csr_exc_ack got %b/%b exp 0000/0000", ack, we_gpr); end
    n_checks++; if (exc.valid !== 1'b1 || exc.cause !== 64'd2 || exc.tval !== 64'h1234) begin n_fail++; $display("FAIL csr_exc got %b/%h/%h exp 1/2/1234", exc.valid, exc.cause, exc.tval); end
    next_cycle();
  endtask

  task automatic test_fence;
    clear_inputs();
    instr[0] = mk(FU_CSR, OP_FENCE, 0, 0);
    for (int k = 1; k < 4; k++) instr[k] = alu(k);
    no_st = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_checks++; if (ack !== 4'b0000 || fence !== 1'b0) begin n_fail++; $display("FAIL fence_wait%0d got %b/%b exp 0000/0", i, ack, fence); end
      next_cycle();
    end
    no_st = 1; #1;
    n_checks++; if (ack !== 4'b0001 || fence !== 1'b1 || fence_i !== 1'b0 || sfence !== 1'b0) begin n_fail++; $display("FAIL fence_rel got %b/%b%b%b exp 0001/100", ack, fence, fence_i, sfence); end
    n_checks++; if (we_gpr !== 4'b0000 || n_retired !== 3'd1) begin n_fail++; $display("FAIL fence_we got %b/%0d exp 0000/1", we_gpr, n_retired); end
    next_cycle();
    instr = '0; for (int k = 0; k < 3; k++) instr[k] = alu(k); #1;
    n_checks++; if (ack !== 4'b0000 || fence !== 1'b0) begin n_fail++; $display("FAIL fence_flush got %b/%b exp 0000/0", ack, fence); end
    next_cycle(); #1;
    n_checks++; if (ack !== 4'b0111) begin n_fail++; $display("FAIL fence_idle got %b exp 0111", ack); end
    next_cycle();
  endtask

  task automatic test_amo;
    clear_inputs();
    instr[0] = mk(FU_STORE, OP_AMO_ADD, 9, 0);
    for (int k = 1; k < 4; k++) instr[k] = alu(k);
    #1;
    n_checks++; if (ack !== 4'b0000 || amo_valid !== 1'b0 || lsu !== 1'b0) begin n_fail++; $display("FAIL amo_c1 got %b/%b/%b exp 0000/0/0", ack, amo_valid, lsu); end
    next_cycle(); #1;
    n_checks++; if (ack !== 4'b0000 || amo_valid !== 1'b1) begin n_fail++; $display("FAIL amo_c2 got %b/%b exp 0000/1", ack, amo_valid); end
    next_cycle();
    amo_resp = '{ack: 1'b1, result: 64'hDEAD}; #1;
    n_checks++; if (ack !== 4'b0001 || flush_commit !== 1'b1) begin n_fail++; $display("FAIL amo_c3 got %b/%b exp 0001/1", ack, flush_commit); end
    n_checks++; if (wdata[0] !== 64'hDEAD || we_gpr !== 4'b0001) begin n_fail++; $display("FAIL amo_wb got %h/%b exp dead/0001", wdata[0], we_gpr); end
    next_cycle();
    amo_resp = '0; for (int k = 0; k < 4; k++) instr[k] = alu(k); #1;
    n_checks++; if (ack !== 4'b0000 || flush_commit !== 1'b0 || amo_valid !== 1'b0) begin n_fail++; $display("FAIL amo_flush got %b/%b/%b exp 0000/0/0", ack, flush_commit, amo_valid); end
    next_cycle(); #1;
    n_checks++; if (ack !== 4'b1111) begin n_fail++; $display("FAIL amo_idle got %b exp 1111", ack); end
    next_cycle();
  endtask

  task automatic test_halt_amo;
    clear_inputs();
    instr[0] = mk(FU_STORE, OP_AMO_SWAP, 3, 0);
    next_cycle();
    halt_i = 1; amo_resp = '{ack: 1'b1, result: 64'h42}; #1;
    n_checks++; if (ack !== 4'b0000 || amo_valid !== 1'b1 || flush_commit !== 1'b0) begin n_fail++; $display("FAIL halt_amo got %b/%b/%b exp 0000/1/0", ack, amo_valid, flush_commit); end
    next_cycle();
    halt_i = 0; #1;
    n_checks++; if (ack !== 4'b0001 || wdata[0] !== 64'h42) begin n_fail++; $display("FAIL halt_amo_rel got %b/%h exp 0001/42", ack, wdata[0]); end
    next_cycle(); clear_inputs(); next_cycle();
  endtask

  task automatic test_flush_drain;
    clear_inputs();
    instr[0] = mk(FU_CSR, OP_FENCE_I, 0, 0); no_st = 0;
    next_cycle();
    flush_i = 1; no_st = 1; #1;
    n_checks++; if (ack !== 4'b0000 || fence_i !== 1'b0) begin n_fail++; $display("FAIL flush_drain got %b/%b exp 0000/0", ack, fence_i); end
    next_cycle();
    flush_i = 0; #1;
    n_checks++; if (ack !== 4'b0000 || fence_i !== 1'b0) begin n_fail++; $display("FAIL flush_idle got %b/%b exp 0000/0", ack, fence_i); end
    next_cycle(); #1;
    n_checks++; if (ack !== 4'b0001 || fence_i !== 1'b1) begin n_fail++; $display("FAIL flush_redo got %b/%b exp 0001/1", ack, fence_i); end
    next_cycle(); clear_inputs(); next_cycle();
  endtask

  task automatic test_reset_drain;
    clear_inputs();
    instr[0] = mk(FU_CSR, OP_SFENCE_VMA, 0, 0); no_st = 0;
    next_cycle(); next_cycle();
    rst_ni = 0; no_st = 1; #1;
    n_checks++; if (ack !== 4'b0000 || sfence !== 1'b0) begin n_fail++; $display("FAIL rst_drain got %b/%b exp 0000/0", ack, sfence); end
    next_cycle();
    rst_ni = 1; #1;
    n_checks++; if (ack !== 4'b0000 || sfence !== 1'b0) begin n_fail++; $display("FAIL rst_idle got %b/%b exp 0000/0", ack, sfence); end
    next_cycle(); #1;
    n_checks++; if (ack !== 4'b0001 || sfence !== 1'b1) begin n_fail++; $display("FAIL rst_redo got %b/%b exp 0001/1", ack, sfence); end
    next_cycle(); clear_inputs(); next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_alu_group();
    test_stores();
    test_step_halt();
    test_exception();
    test_fp();
    test_csr();
    test_fence();
    test_amo();
    test_halt_amo();
    test_flush_drain();
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
